// File: rtl/fpu_pkg.sv
// Shared constants, state encoding and payload types for the FPU operation port.
package fpu_pkg;

    localparam int unsigned FP_W  = 32;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned SEQ_W = 8;

    localparam logic [SEL_W-1:0] SEL_ADD = 2'b00;
    localparam logic [SEL_W-1:0] SEL_SUB = 2'b01;
    localparam logic [SEL_W-1:0] SEL_MUL = 2'b10;
    localparam logic [SEL_W-1:0] SEL_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } issuer_state_t;

    typedef struct packed {
        logic [FP_W-1:0]  a;
        logic [FP_W-1:0]  b;
        logic [SEL_W-1:0] sel;
        logic             round;
    } fpu_cmd_t;

    typedef struct packed {
        logic [FP_W-1:0]  y;
        logic             overflow;
        logic             error;
        logic [SEQ_W-1:0] seq;
    } fpu_rsp_t;

endpackage

// File: rtl/fpu_op_issuer_sat_counter.sv
// Saturating up-counter: increments by one when enabled, sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/fpu_op_issuer.sv
// Host-side issuer: accepts one command, pulses the FPU start, waits a fixed
// latency, then holds the captured result as a valid/ready response.
module fpu_op_issuer
    import fpu_pkg::*;
#(
    parameter int unsigned LATENCY = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [FP_W-1:0]    cmd_a,
    input  logic [FP_W-1:0]    cmd_b,
    input  logic [SEL_W-1:0]   cmd_sel,
    input  logic               cmd_round,
    output logic [FP_W-1:0]    fpu_A,
    output logic [FP_W-1:0]    fpu_B,
    output logic [SEL_W-1:0]   fpu_Sel,
    output logic               fpu_round,
    output logic               fpu_start,
    input  logic [FP_W-1:0]    fpu_Y,
    input  logic               fpu_Overflow,
    input  logic               fpu_Error,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [FP_W-1:0]    rsp_y,
    output logic               rsp_overflow,
    output logic               rsp_error,
    output logic [SEQ_W-1:0]   rsp_seq,
    output logic [CNT_W-1:0]   op_count,
    output logic [CNT_W-1:0]   ovf_count,
    output logic [CNT_W-1:0]   err_count
);

    localparam int unsigned       WCNT_W    = $clog2(LATENCY + 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(LATENCY - 1);

    issuer_state_t     state;
    issuer_state_t     state_next;
    logic [WCNT_W-1:0] wait_cnt;
    logic [SEQ_W-1:0]  seq;
    logic [SEQ_W-1:0]  seq_cur;
    fpu_cmd_t          op_q;
    fpu_rsp_t          rsp_q;
    logic              accept;
    logic              capture;
    logic              rsp_done;

    // Handshakes qualify on the registered flags so nothing fires in the reset-release cycle.
    assign accept   = cmd_valid & cmd_ready;
    assign rsp_done = rsp_valid & rsp_ready;
    assign capture  = (state == WAIT) && (wait_cnt == WAIT_LAST);

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept)   state_next = ISSUE;
            ISSUE:                 state_next = WAIT;
            WAIT:    if (capture)  state_next = RESP;
            RESP:    if (rsp_done) state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    // Handshake flags and start pulse are registered decodes of the next state.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            cmd_ready <= 1'b0;
            fpu_start <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            cmd_ready <= (state_next == IDLE);
            fpu_start <= (state_next == ISSUE);
            rsp_valid <= (state_next == RESP);
        end
    end

    // Counts WAIT cycles; reaches LATENCY on the capture edge.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            op_q    <= '0;
            seq     <= '0;
            seq_cur <= '0;
        end else if (accept) begin
            op_q    <= fpu_cmd_t'{a: cmd_a, b: cmd_b, sel: cmd_sel, round: cmd_round};
            seq_cur <= seq;
            seq     <= seq + SEQ_W'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            rsp_q <= '0;
        end else if (capture) begin
            rsp_q <= fpu_rsp_t'{y: fpu_Y, overflow: fpu_Overflow, error: fpu_Error, seq: seq_cur};
        end
    end

    assign fpu_A        = op_q.a;
    assign fpu_B        = op_q.b;
    assign fpu_Sel      = op_q.sel;
    assign fpu_round    = op_q.round;
    assign rsp_y        = rsp_q.y;
    assign rsp_overflow = rsp_q.overflow;
    assign rsp_error    = rsp_q.error;
    assign rsp_seq      = rsp_q.seq;

    sat_counter #(.W(CNT_W)) u_op_cnt (
        .clk   (Clock),
        .rst_n (Reset),
        .en    (rsp_done),
        .count (op_count)
    );

    sat_counter #(.W(CNT_W)) u_ovf_cnt (
        .clk   (Clock),
        .rst_n (Reset),
        .en    (rsp_done & rsp_q.overflow),
        .count (ovf_count)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (Clock),
        .rst_n (Reset),
        .en    (rsp_done & rsp_q.error),
        .count (err_count)
    );

endmodule

// File: tb/tb_fpu_op_issuer.sv
// Directed bench for fpu_op_issuer: vector table plus reset, back-to-back and saturation sequences.
module tb_fpu_op_issuer;
    import fpu_pkg::*;

    localparam int unsigned LAT = 8;
    localparam int unsigned CW  = 16;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic        Reset;
    logic        cmd_valid, cmd_ready, cmd_round;
    logic [31:0] cmd_a, cmd_b;
    logic [1:0]  cmd_sel;
    logic [31:0] fpu_A, fpu_B, fpu_Y;
    logic [1:0]  fpu_Sel;
    logic        fpu_round, fpu_start, fpu_Overflow, fpu_Error;
    logic        rsp_valid, rsp_ready, rsp_overflow, rsp_error;
    logic [31:0] rsp_y;
    logic [7:0]  rsp_seq;
    logic [CW-1:0] op_count, ovf_count, err_count;

    fpu_op_issuer #(.LATENCY(LAT), .CNT_W(CW)) dut (
        .Clock(Clock), .Reset(Reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_round(cmd_round),
        .fpu_A(fpu_A), .fpu_B(fpu_B), .fpu_Sel(fpu_Sel), .fpu_round(fpu_round),
        .fpu_start(fpu_start), .fpu_Y(fpu_Y), .fpu_Overflow(fpu_Overflow), .fpu_Error(fpu_Error),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
        .rsp_overflow(rsp_overflow), .rsp_error(rsp_error), .rsp_seq(rsp_seq),
        .op_count(op_count), .ovf_count(ovf_count), .err_count(err_count)
    );

    // Narrow-counter instance for saturation
    logic        s_cmd_valid, s_cmd_ready, s_fpu_round, s_fpu_start;
    logic [31:0] s_fpu_A, s_fpu_B, s_rsp_y;
    logic [1:0]  s_fpu_Sel;
    logic        s_rsp_valid, s_rsp_ready, s_rsp_overflow, s_rsp_error;
    logic [7:0]  s_rsp_seq;
    logic [1:0]  s_op_count, s_ovf_count, s_err_count;
    logic [31:0] s_zero32 = 32'h0;
    logic [31:0] s_nan    = 32'h7FC0_0000;
    logic [1:0]  s_sel    = SEL_DIV;
    logic        s_lo     = 1'b0;
    logic        s_hi     = 1'b1;

    fpu_op_issuer #(.LATENCY(1), .CNT_W(2)) dut_small (
        .Clock(Clock), .Reset(Reset),
        .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready),
        .cmd_a(s_zero32), .cmd_b(s_zero32), .cmd_sel(s_sel), .cmd_round(s_lo),
        .fpu_A(s_fpu_A), .fpu_B(s_fpu_B), .fpu_Sel(s_fpu_Sel), .fpu_round(s_fpu_round),
        .fpu_start(s_fpu_start), .fpu_Y(s_nan), .fpu_Overflow(s_lo), .fpu_Error(s_hi),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_y(s_rsp_y),
        .rsp_overflow(s_rsp_overflow), .rsp_error(s_rsp_error), .rsp_seq(s_rsp_seq),
        .op_count(s_op_count), .ovf_count(s_ovf_count), .err_count(s_err_count)
    );

    // FPU stub: result is valid only in the single cycle LAT cycles after start, inverted otherwise.
    logic [31:0] m_y;
    logic        m_ovf, m_err;
    int unsigned fcnt = 0;
    always @(posedge Clock) begin
        if (fpu_start)        fcnt <= 1;
        else if (fcnt == LAT) fcnt <= 0;
        else if (fcnt != 0)   fcnt <= fcnt + 1;
    end
    assign fpu_Y        = (fcnt == LAT) ? m_y   : ~m_y;
    assign fpu_Overflow = (fcnt == LAT) ? m_ovf : ~m_ovf;
    assign fpu_Error    = (fcnt == LAT) ? m_err : ~m_err;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  sel;
        logic        rnd;
        logic [31:0] y;
        logic        ovf;
        logic        err;
        int unsigned hold;
        logic        early;
    } vec_t;

    vec_t vecs[5];
    int errors = 0;
    int checks = 0;
    logic [7:0] exp_seq = 8'd0;
    int exp_op = 0, exp_ovf = 0, exp_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int sat_inc(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    task automatic run_op(input vec_t v);
        int starts, start_k, rsp_k, busy_ready, unstable, k;
        logic [31:0] y0;
        logic [9:0]  f0;
        @(negedge Clock);
        k = 0;
        while (!cmd_ready && k < 100) begin
            @(negedge Clock);
            k++;
        end
        if (!cmd_ready) begin
            chk("cmd_ready_timeout", 64'(cmd_ready), 64'(1));
            return;
        end
        m_y = v.y; m_ovf = v.ovf; m_err = v.err;
        cmd_valid = 1'b1; cmd_a = v.a; cmd_b = v.b; cmd_sel = v.sel; cmd_round = v.rnd;
        rsp_ready = v.early;
        @(posedge Clock);
        @(negedge Clock);
        cmd_valid = 1'b0;
        chk("fpu_A", 64'(fpu_A), 64'(v.a));
        chk("fpu_B", 64'(fpu_B), 64'(v.b));
        chk("fpu_sel_round", 64'({fpu_Sel, fpu_round}), 64'({v.sel, v.rnd}));
        // Offer a conflicting command while busy; it must be ignored.
        cmd_valid = 1'b1; cmd_a = 32'hBAD0_0000; cmd_b = 32'hBAD0_0001; cmd_sel = ~v.sel; cmd_round = ~v.rnd;
        starts = 0; start_k = -1; rsp_k = -1; busy_ready = 0;
        for (int i = 0; i < 40 && rsp_k < 0; i++) begin
            if (i > 0) @(negedge Clock);
            if (fpu_start) begin
                starts++;
                if (starts == 1) start_k = i;
            end
            if (cmd_ready) busy_ready++;
            if (rsp_valid) rsp_k = i;
        end
        chk("start_pulses", 64'(starts), 64'(1));
        chk("start_cycle", 64'(start_k), 64'(0));
        chk("rsp_latency", 64'(rsp_k), 64'(LAT + 1));
        chk("rsp_y", 64'(rsp_y), 64'(v.y));
        chk("rsp_flags", 64'({rsp_overflow, rsp_error}), 64'({v.ovf, v.err}));
        chk("rsp_seq", 64'(rsp_seq), 64'(exp_seq));
        y0 = rsp_y;
        f0 = {rsp_overflow, rsp_error, rsp_seq};
        unstable = 0;
        for (int h = 0; h < int'(v.hold); h++) begin
            @(negedge Clock);
            if (rsp_y !== y0 || {rsp_overflow, rsp_error, rsp_seq} !== f0 || !rsp_valid) unstable++;
            if (cmd_ready) busy_ready++;
            if (fpu_A !== v.a || fpu_B !== v.b) unstable++;
        end
        chk("rsp_hold_stable", 64'(unstable), 64'(0));
        chk("cmd_ready_busy", 64'(busy_ready), 64'(0));
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        rsp_ready = 1'b0;
        exp_seq = exp_seq + 8'd1;
        exp_op  = sat_inc(exp_op, 65535);
        if (v.ovf) exp_ovf = sat_inc(exp_ovf, 65535);
        if (v.err) exp_err = sat_inc(exp_err, 65535);
        chk("post_hs_ready_valid", 64'({cmd_ready, rsp_valid}), 64'(2'b10));
        chk("op_count", 64'(op_count), 64'(exp_op));
        chk("ovf_count", 64'(ovf_count), 64'(exp_ovf));
        chk("err_count", 64'(err_count), 64'(exp_err));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int accepts, resps, last_acc, bad_space, bad_seq, quiet;
        logic saw255, wrapped;

        vecs[0] = '{a: 32'h4370_0000, b: 32'h42F0_0000, sel: SEL_ADD, rnd: 1'b0,
                    y: 32'h43B4_0000, ovf: 1'b0, err: 1'b0, hold: 0, early: 1'b0};
        vecs[1] = '{a: 32'h0000_0000, b: 32'h0000_0000, sel: SEL_DIV, rnd: 1'b0,
                    y: 32'h7FC0_0000, ovf: 1'b0, err: 1'b1, hold: 3, early: 1'b0};
        vecs[2] = '{a: 32'h7F01_0000, b: 32'h7F01_0000, sel: SEL_ADD, rnd: 1'b0,
                    y: 32'h7F80_0000, ovf: 1'b1, err: 1'b0, hold: 20, early: 1'b0};
        vecs[3] = '{a: 32'h3F80_0000, b: 32'h4000_0000, sel: SEL_MUL, rnd: 1'b1,
                    y: 32'h4000_0000, ovf: 1'b0, err: 1'b0, hold: 1, early: 1'b0};
        vecs[4] = '{a: 32'h4040_0000, b: 32'h3F80_0000, sel: SEL_SUB, rnd: 1'b0,
                    y: 32'h4000_0000, ovf: 1'b0, err: 1'b0, hold: 0, early: 1'b1};

        Reset = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = '0; cmd_round = 1'b0;
        rsp_ready = 1'b0; m_y = '0; m_ovf = 1'b0; m_err = 1'b0;
        s_cmd_valid = 1'b0; s_rsp_ready = 1'b0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        chk("reset_ctl", 64'({cmd_ready, fpu_start, rsp_valid, rsp_overflow, rsp_error}), 64'(0));
        chk("reset_counters", 64'({op_count, ovf_count, err_count}), 64'(0));
        Reset = 1'b1;
        @(negedge Clock);
        chk("ready_after_reset", 64'(cmd_ready), 64'(1));

        for (int i = 0; i < 5; i++) run_op(vecs[i]);

        // Back-to-back: cmd_valid and rsp_ready held high for 300 commands.
        @(negedge Clock);
        m_y = 32'h1234_5678; m_ovf = 1'b0; m_err = 1'b0;
        cmd_a = 32'h3F80_0000; cmd_b = 32'h3F80_0000; cmd_sel = SEL_ADD; cmd_round = 1'b0;
        cmd_valid = 1'b1; rsp_ready = 1'b1;
        accepts = 0; resps = 0; last_acc = -1; bad_space = 0; bad_seq = 0;
        saw255 = 1'b0; wrapped = 1'b0;
        for (int cyc = 0; cyc < 300 * int'(LAT + 3) + 50 && resps < 300; cyc++) begin
            if (accepts >= 300) cmd_valid = 1'b0;
            if (cmd_valid && cmd_ready) begin
                if (last_acc >= 0 && (cyc - last_acc) != int'(LAT + 3)) bad_space++;
                last_acc = cyc;
                accepts++;
            end
            if (rsp_valid && rsp_ready) begin
                if (rsp_seq !== exp_seq) bad_seq++;
                if (rsp_seq == 8'd255) saw255 = 1'b1;
                else if (saw255 && rsp_seq == 8'd0) wrapped = 1'b1;
                exp_seq = exp_seq + 8'd1;
                exp_op  = sat_inc(exp_op, 65535);
                resps++;
            end
            @(negedge Clock);
        end
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        chk("b2b_accepts", 64'(accepts), 64'(300));
        chk("b2b_responses", 64'(resps), 64'(300));
        chk("b2b_spacing", 64'(bad_space), 64'(0));
        chk("b2b_seq", 64'(bad_seq), 64'(0));
        chk("b2b_seq_wrap", 64'(wrapped), 64'(1));
        chk("b2b_op_count", 64'(op_count), 64'(exp_op));

        // Reset pulsed during WAIT of an in-flight op.
        @(negedge Clock);
        m_y = 32'h4120_0000;
        cmd_valid = 1'b1; cmd_a = 32'h4100_0000; cmd_b = 32'h3F80_0000; cmd_sel = SEL_ADD; cmd_round = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        cmd_valid = 1'b0;
        repeat (4) @(negedge Clock);
        Reset = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        chk("midreset_ctl", 64'({cmd_ready, fpu_start, rsp_valid, rsp_overflow, rsp_error}), 64'(0));
        chk("midreset_fpu_ops", {fpu_A, fpu_B}, 64'(0));
        chk("midreset_sel_round", 64'({fpu_Sel, fpu_round}), 64'(0));
        chk("midreset_rsp", 64'({rsp_y, rsp_seq}), 64'(0));
        chk("midreset_counters", 64'({op_count, ovf_count, err_count}), 64'(0));
        Reset = 1'b1;
        @(negedge Clock);
        chk("midreset_ready", 64'(cmd_ready), 64'(1));
        quiet = 0;
        for (int i = 0; i < int'(LAT + 4); i++) begin
            if (rsp_valid || fpu_start) quiet++;
            @(negedge Clock);
        end
        chk("midreset_no_response", 64'(quiet), 64'(0));
        exp_seq = 8'd0; exp_op = 0; exp_ovf = 0; exp_err = 0;
        run_op(vecs[0]);

        // Five error ops against the 2-bit counter build.
        accepts = 0; resps = 0;
        s_rsp_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge Clock);
            s_cmd_valid = (accepts < 5);
            if (s_cmd_valid && s_cmd_ready) accepts++;
            if (s_rsp_valid && s_rsp_ready) resps++;
        end
        s_cmd_valid = 1'b0; s_rsp_ready = 1'b0;
        chk("sat_responses", 64'(resps), 64'(5));
        chk("sat_err_count", 64'(s_err_count), 64'(3));
        chk("sat_op_count", 64'(s_op_count), 64'(3));
        chk("sat_ovf_count", 64'(s_ovf_count), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpu_op_issuer.md
# fpu_op_issuer

Host-side initiator for the FPU operation port. It accepts one operation per valid/ready command handshake and drives the FPU's A/B/Sel/round operands with a single-cycle `start` pulse. It waits a fixed result latency, then captures Y/Overflow/Error into a valid/ready response. It sits between the command-producing logic (sequencer or bus bridge) and the FPU instance, and also keeps saturating status counters.

## Interface
- `LATENCY`, default 8: number of cycles from the FPU `start` cycle to a stable Y/Overflow/Error. Legal range is ≥1.
- `CNT_W`, default 16: width of the status counters.

Ports (name, direction, width, meaning):
- `Clock` in 1: single clock; all logic on the rising edge.
- `Reset` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: a command is offered.
- `cmd_ready` out 1: the issuer can accept a command.
- `cmd_a` in 32: operand A.
- `cmd_b` in 32: operand B.
- `cmd_sel` in 2: operation select; 00 add, 01 sub, 10 mul, 11 div.
- `cmd_round` in 1: rounding-mode bit passed to the FPU.
- `fpu_A` out 32: operand A to the FPU.
- `fpu_B` out 32: operand B to the FPU.
- `fpu_Sel` out 2: operation select to the FPU.
- `fpu_round` out 1: rounding-mode bit to the FPU.
- `fpu_start` out 1: one-cycle launch pulse to the FPU.
- `fpu_Y` in 32: FPU result.
- `fpu_Overflow` in 1: FPU overflow flag.
- `fpu_Error` in 1: FPU error flag.
- `rsp_valid` out 1: a response is held.
- `rsp_ready` in 1: the consumer accepts the response.
- `rsp_y` out 32: captured result.
- `rsp_overflow` out 1: captured overflow flag.
- `rsp_error` out 1: captured error flag.
- `rsp_seq` out 8: sequence number of the command this response belongs to.
- `op_count` out CNT_W: completed operations, saturating.
- `ovf_count` out CNT_W: responses with overflow set, saturating.
- `err_count` out CNT_W: responses with error set, saturating.

## Operation
- The FSM has four states:
  - IDLE → ISSUE on the cycle `cmd_valid && cmd_ready`.
  - ISSUE → WAIT after exactly one cycle.
  - WAIT → RESP when the wait counter reaches LATENCY.
  - RESP → IDLE on the cycle `rsp_valid && rsp_ready`.
- `cmd_ready` = 1 only in IDLE. It is a registered-state decode with no combinational path from `cmd_valid`.
- On accept, latch `cmd_a`, `cmd_b`, `cmd_sel` and `cmd_round` into the `fpu_*` operand registers. Hold them stable through ISSUE, WAIT and RESP; change them only on the next accept.
- `fpu_start` = 1 only in ISSUE.
- WAIT counter:
  - Cleared on entry to ISSUE.
  - Increments each WAIT cycle.
  - Width is $clog2(LATENCY+1).
- On the WAIT→RESP edge, capture `fpu_Y`, `fpu_Overflow` and `fpu_Error` into the `rsp_*` registers. Hold them while `rsp_valid` = 1, even if the FPU outputs change.
- `rsp_seq`:
  - An internal 8-bit `seq` register starts at 0 and increments on each command accept.
  - `rsp_seq` is updated to the accepted command's `seq` value at capture.
  - `seq` wraps 255→0.
- Counters update on the response handshake:
  - `op_count` += 1.
  - `ovf_count` += `rsp_overflow`.
  - `err_count` += `rsp_error`.
  - Each counter saturates at all-ones and never wraps.
- The block does not interpret `cmd_sel` values; all four codes are legal and are passed through unchanged.

## Timing
- Reset (Reset = 0 at a rising edge), whether applied idle or mid-operation:
  - State returns to IDLE.
  - All outputs = 0, including `cmd_ready`, `fpu_*`, `rsp_*` and the counters; `seq` = 0.
  - `cmd_ready` = 1 from the first cycle after Reset deasserts.
  - Any in-flight operation is dropped: no response and no counter update.
- Command accepted at edge t:
  - `fpu_start` = 1 during cycle t+1 only.
  - Capture happens at edge t+1+LATENCY.
  - `rsp_valid` = 1 from cycle t+2+LATENCY.
- Response accepted at edge r: `cmd_ready` = 1 from cycle r+1. Minimum issue-to-issue spacing is LATENCY+3 cycles.
- `rsp_ready` held low: remain in RESP indefinitely with all `rsp_*` outputs stable.
- `cmd_valid` asserted outside IDLE: ignored and not accepted. The producer must hold its command until it sees `cmd_ready`.
- `rsp_ready` high before `rsp_valid`: no effect.

## Structure
- Shared package `fpu_pkg` holds:
  - The SEL_ADD/SEL_SUB/SEL_MUL/SEL_DIV 2-bit constants.
  - The `issuer_state_t` enum (IDLE, ISSUE, WAIT, RESP).
  - The FP32 width constant.
- One natural sub-module, `sat_counter`, parameterised by width with an increment-enable input. It is instantiated three times, for op, ovf and err.

## Test plan
- Reset released, then A = 0x43700000, B = 0x42F00000, Sel = 00, round = 0, LATENCY = 8 → `fpu_start` high in exactly one cycle (t+1), `rsp_valid` at t+10, `rsp_y` = 0x43B40000, flags 0, `rsp_seq` = 0, `op_count` = 1 after handshake.
- A = 0x00000000, B = 0x00000000, Sel = 11 → `rsp_error` = 1; `err_count` = 1 after handshake; `ovf_count` unchanged.
- A = 0x7F010000, B = 0x7F010000, Sel = 00 with `rsp_ready` held low for 20 cycles and the FPU outputs perturbed → `rsp_*` unchanged until the handshake; `rsp_overflow` = 1; `cmd_ready` = 0 throughout.
- `cmd_valid` held high continuously for 300 commands → accepts spaced exactly LATENCY+3 cycles apart; `rsp_seq` wraps 255→0.
- Reset pulsed low during WAIT of an in-flight op → next cycle all outputs 0, no response emitted, counters 0, next command gets `rsp_seq` = 0.
- Force the counters near all-ones (CNT_W = 2 build) and run 5 error ops → `err_count` sticks at 3.
